// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes, incoming
// R-type funct codes and the internal ALU operation codes.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_IN_ADDU = 6'b001011;
  localparam logic [5:0] FN_IN_SUBU = 6'b001101;
  localparam logic [5:0] FN_IN_AND  = 6'b010010;
  localparam logic [5:0] FN_IN_SLL  = 6'b100110;

  localparam logic [5:0] ALU_NOP  = 6'h00;
  localparam logic [5:0] ALU_ADDU = 6'h09;
  localparam logic [5:0] ALU_SUBU = 6'h0A;
  localparam logic [5:0] ALU_AND  = 6'h11;
  localparam logic [5:0] ALU_SLL  = 6'h21;

  // True when an R-type funct field has a translation to an ALU op.
  function automatic logic is_supported_funct(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_IN_ADDU: ok = 1'b1;
      FN_IN_SUBU: ok = 1'b1;
      FN_IN_AND:  ok = 1'b1;
      FN_IN_SLL:  ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decode producing the next ALU op code and the
// unsupported-R-type flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [5:0] funct_next,
  output logic       illegal_next
);

  logic [5:0] rtype_op_s;
  logic       rtype_ok_s;

  // Translate an R-type funct field into the internal ALU op encoding.
  always_comb begin
    rtype_op_s = ALU_NOP;
    case (funct)
      FN_IN_ADDU: rtype_op_s = ALU_ADDU;
      FN_IN_SUBU: rtype_op_s = ALU_SUBU;
      FN_IN_AND:  rtype_op_s = ALU_AND;
      FN_IN_SLL:  rtype_op_s = ALU_SLL;
      default:    rtype_op_s = ALU_NOP;
    endcase
  end

  assign rtype_ok_s = is_supported_funct(funct);

  // Select the ALU op by operation class; only R-type looks at funct.
  always_comb begin
    funct_next   = ALU_NOP;
    illegal_next = 1'b0;
    case (ALUOp)
      ALUOP_MEM: begin
        funct_next   = ALU_NOP;
        illegal_next = 1'b0;
      end
      ALUOP_BR: begin
        funct_next   = ALU_SUBU;
        illegal_next = 1'b0;
      end
      ALUOP_RTYPE: begin
        funct_next   = rtype_op_s;
        illegal_next = ~rtype_ok_s;
      end
      ALUOP_RSVD: begin
        funct_next   = ALU_NOP;
        illegal_next = 1'b0;
      end
      default: begin
        funct_next   = ALU_NOP;
        illegal_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// Registered ALU control decoder: decoded op and illegal flag appear one
// clock after the inputs, and clear asynchronously on rst_n.
module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [5:0] Funct,
  output logic       Illegal
);

  logic [5:0] funct_next_s;
  logic       illegal_next_s;
  logic [5:0] funct_r;
  logic       illegal_r;

  alu_ctrl_decode u_decode (
    .ALUOp        (ALUOp),
    .funct        (funct),
    .funct_next   (funct_next_s),
    .illegal_next (illegal_next_s)
  );

  // Output register; reset forces a NOP with no illegal indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct_r   <= ALU_NOP;
      illegal_r <= 1'b0;
    end else begin
      funct_r   <= funct_next_s;
      illegal_r <= illegal_next_s;
    end
  end

  assign Funct   = funct_r;
  assign Illegal = illegal_r;

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control: reset, class decode, R-type
// translation, illegal detection, input hold between edges, mid-stream reset.
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [5:0] Funct;
  logic       Illegal;

  int errors = 0;
  int checks = 0;

  alu_control dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ALUOp   (ALUOp),
    .funct   (funct),
    .Funct   (Funct),
    .Illegal (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn);
    @(negedge clk);
    ALUOp = op;
    funct = fn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ALUOp = 2'b10;
    funct = 6'b001011;
    #2;
    checks++;
    if (Funct !== 6'h00) begin
      errors++;
      $display("FAIL reset_funct: got %h expected %h", Funct, 6'h00);
    end
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b expected %b", Illegal, 1'b0);
    end
    tick();
    checks++;
    if (Funct !== 6'h00) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", Funct, 6'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mem();
    drive(2'b00, 6'b001011);
    tick();
    checks++;
    if (Funct !== 6'h00 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL mem_class: got %h/%b expected %h/%b", Funct, Illegal, 6'h00, 1'b0);
    end
    drive(2'b00, 6'b111111);
    tick();
    checks++;
    if (Funct !== 6'h00 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL mem_badfunct: got %h/%b expected %h/%b", Funct, Illegal, 6'h00, 1'b0);
    end
  endtask

  task automatic test_rtype_seq();
    logic [5:0] fin [4];
    logic [5:0] fexp [4];
    fin[0] = 6'b001101; fexp[0] = 6'h0A;
    fin[1] = 6'b010010; fexp[1] = 6'h11;
    fin[2] = 6'b100110; fexp[2] = 6'h21;
    fin[3] = 6'b001011; fexp[3] = 6'h09;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, fin[i]);
      tick();
      checks++;
      if (Funct !== fexp[i] || Illegal !== 1'b0) begin
        errors++;
        $display("FAIL rtype_%0d: got %h/%b expected %h/%b", i, Funct, Illegal, fexp[i], 1'b0);
      end
    end
  endtask

  task automatic test_hold_between_edges();
    // Output currently 6'h09; a new input must not show until the edge.
    drive(2'b10, 6'b100110);
    #1;
    checks++;
    if (Funct !== 6'h09) begin
      errors++;
      $display("FAIL hold_before_edge: got %h expected %h", Funct, 6'h09);
    end
    tick();
    checks++;
    if (Funct !== 6'h21) begin
      errors++;
      $display("FAIL hold_after_edge: got %h expected %h", Funct, 6'h21);
    end
    tick();
    checks++;
    if (Funct !== 6'h21 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL hold_repeat: got %h/%b expected %h/%b", Funct, Illegal, 6'h21, 1'b0);
    end
  endtask

  task automatic test_illegal();
    drive(2'b10, 6'b111111);
    tick();
    checks++;
    if (Funct !== 6'h00 || Illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set: got %h/%b expected %h/%b", Funct, Illegal, 6'h00, 1'b1);
    end
    drive(2'b10, 6'b001011);
    tick();
    checks++;
    if (Funct !== 6'h09 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got %h/%b expected %h/%b", Funct, Illegal, 6'h09, 1'b0);
    end
    drive(2'b10, 6'b000000);
    tick();
    checks++;
    if (Illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_zero_funct: got %b expected %b", Illegal, 1'b1);
    end
    // Asynchronous reset must drop Illegal between edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_async_reset: got %b expected %b", Illegal, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_branch_reserved();
    drive(2'b01, 6'b100110);
    tick();
    checks++;
    if (Funct !== 6'h0A || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL branch: got %h/%b expected %h/%b", Funct, Illegal, 6'h0A, 1'b0);
    end
    drive(2'b11, 6'b100110);
    tick();
    checks++;
    if (Funct !== 6'h00 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL reserved: got %h/%b expected %h/%b", Funct, Illegal, 6'h00, 1'b0);
    end
    drive(2'b11, 6'b111111);
    tick();
    checks++;
    if (Funct !== 6'h00 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL reserved_badfunct: got %h/%b expected %h/%b", Funct, Illegal, 6'h00, 1'b0);
    end
  endtask

  task automatic test_reset_midstream();
    drive(2'b10, 6'b100110);
    tick();
    checks++;
    if (Funct !== 6'h21) begin
      errors++;
      $display("FAIL mid_pre: got %h expected %h", Funct, 6'h21);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Funct !== 6'h00) begin
      errors++;
      $display("FAIL mid_async: got %h expected %h", Funct, 6'h00);
    end
    tick();
    checks++;
    if (Funct !== 6'h00) begin
      errors++;
      $display("FAIL mid_hold: got %h expected %h", Funct, 6'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (Funct !== 6'h00) begin
      errors++;
      $display("FAIL mid_release: got %h expected %h", Funct, 6'h00);
    end
    tick();
    checks++;
    if (Funct !== 6'h21 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume: got %h/%b expected %h/%b", Funct, Illegal, 6'h21, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_rtype_seq();
    test_hold_between_edges();
    test_illegal();
    test_branch_reserved();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
